// File: rtl/instr_fetch_seq.sv
// Program sequencer: fetches 16-bit words from a synchronous instruction memory and issues them to the processor (optional FETCH_STEP_EN adds a step gate).
// Latency: start -> mem_rd 1 cycle -> Run 3 cycles; Done -> next mem_rd 1 cycle (2 cycles plus the step wait with FETCH_STEP_EN).
// Backpressure: holds each word in EXEC until Done; a watchdog of TIMEOUT cycles halts the sequencer with timeout_err.
module instr_fetch_seq #(
    parameter int              AW       = 8,
    parameter logic [2:0]      HALT_OP  = 3'b111,
    parameter int              TIMEOUT  = 15,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          Rest,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [15:0]   mem_data,
    input  logic          Done,
`ifdef FETCH_STEP_EN
    input  logic          step,
`endif
    output logic [15:0]   Din,
    output logic          Run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          timeout_err,
    output logic [15:0]   instr_cnt
);

    localparam int WW = $clog2(TIMEOUT + 1);
    // The timeout fires on the TIMEOUT-th EXEC cycle, when the counter still reads TIMEOUT-1.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEMWAIT,
        S_ISSUE,
        S_EXEC,
`ifdef FETCH_STEP_EN
        S_STEP_WAIT,
`endif
        S_HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] watchdog;
    logic          din_ld;
    logic          halt_set;
    logic          to_set;
    logic          cnt_inc;

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        Run       = 1'b0;
        busy      = 1'b0;
        din_ld    = 1'b0;
        halt_set  = 1'b0;
        to_set    = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_rd    = 1'b1;
                busy      = 1'b1;
                state_nxt = S_MEMWAIT;
            end
            S_MEMWAIT: begin
                busy = 1'b1;
                if (mem_data[15:13] == HALT_OP) begin
                    halt_set  = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    din_ld    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                Run       = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                // Done takes priority over a watchdog expiry in the same cycle.
                if (Done) begin
                    cnt_inc = 1'b1;
`ifdef FETCH_STEP_EN
                    state_nxt = S_STEP_WAIT;
`else
                    state_nxt = S_FETCH;
`endif
                end else if (watchdog == WD_LAST) begin
                    halt_set  = 1'b1;
                    to_set    = 1'b1;
                    state_nxt = S_HALT;
                end
            end
`ifdef FETCH_STEP_EN
            S_STEP_WAIT: begin
                busy = 1'b1;
                if (step) state_nxt = S_FETCH;
            end
`endif
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rest) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            Din         <= '0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            instr_cnt   <= '0;
            watchdog    <= '0;
        end else begin
            state <= state_nxt;
            if (din_ld) begin
                Din <= mem_data;
                pc  <= pc + 1'b1;
            end
            if (state == S_ISSUE) begin
                watchdog <= '0;
            end else if (state == S_EXEC) begin
                watchdog <= watchdog + 1'b1;
            end
            if (halt_set) halted <= 1'b1;
            if (to_set) timeout_err <= 1'b1;
            if (cnt_inc && (instr_cnt != 16'hFFFF)) instr_cnt <= instr_cnt + 16'd1;
        end
    end

    assign mem_addr = pc;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: two instances (RESET_PC 0 and FF) checked every cycle against an event-scheduled model.
module tb_instr_fetch_seq;
    localparam int         TIMEOUT = 15;
    localparam logic [7:0] RPC0    = 8'h00;
    localparam logic [7:0] RPC1    = 8'hFF;

    logic            clk = 1'b0;
    logic [1:0]      Rest;
    logic [1:0]      start;
    logic [1:0]      Done = '0;
    logic [1:0]      step = '0;
    logic [1:0]      mem_rd, Run, busy, halted, timeout_err;
    logic [1:0][7:0] mem_addr, pc;
    logic [1:0][15:0] mem_data, Din, instr_cnt;
    logic [15:0]     mem [2][256];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // stimulus controls, written by the main sequence only
    int done_delay [2];
    bit done_rand  [2];
    bit done_force [2];
    bit step_hold  [2];
    bit step_rand  [2];
    int last_run_cyc [2];

    logic [15:0] run_q0 [$];
    int          run_c0 [$];
    logic [7:0]  rd_q0  [$];
    int          rd_c0  [$];
    logic [7:0]  rd_q1  [$];

    // model: event schedule (cycle numbers) rather than a state machine
    bit          m_idle [2];
    bit          m_halt [2];
    bit          m_to   [2];
    bit          m_sw   [2];
    logic [7:0]  m_pc   [2];
    logic [15:0] m_din  [2];
    logic [15:0] m_cnt  [2];
    int          f_at   [2];
    int          r_at   [2];
    int          x_lo   [2];
    int          x_hi   [2];

    instr_fetch_seq #(.AW(8), .HALT_OP(3'b111), .TIMEOUT(TIMEOUT), .RESET_PC(RPC0)) dut0 (
        .clk(clk), .Rest(Rest[0]), .start(start[0]), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
        .mem_data(mem_data[0]), .Done(Done[0]),
`ifdef FETCH_STEP_EN
        .step(step[0]),
`endif
        .Din(Din[0]), .Run(Run[0]), .pc(pc[0]), .busy(busy[0]), .halted(halted[0]),
        .timeout_err(timeout_err[0]), .instr_cnt(instr_cnt[0])
    );

    instr_fetch_seq #(.AW(8), .HALT_OP(3'b111), .TIMEOUT(TIMEOUT), .RESET_PC(RPC1)) dut1 (
        .clk(clk), .Rest(Rest[1]), .start(start[1]), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
        .mem_data(mem_data[1]), .Done(Done[1]),
`ifdef FETCH_STEP_EN
        .step(step[1]),
`endif
        .Din(Din[1]), .Run(Run[1]), .pc(pc[1]), .busy(busy[1]), .halted(halted[1]),
        .timeout_err(timeout_err[1]), .instr_cnt(instr_cnt[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (mem_rd[k]) mem_data[k] <= mem[k][mem_addr[k]];
    end

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, k, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin : model
        int n;
        logic [15:0] w;
        n = cyc;
        for (int k = 0; k < 2; k++) begin
            if (Rest[k]) begin
                m_idle[k] = 1'b1; m_halt[k] = 1'b0; m_to[k] = 1'b0; m_sw[k] = 1'b0;
                m_pc[k]   = (k == 0) ? RPC0 : RPC1;
                m_din[k]  = '0; m_cnt[k] = '0;
                f_at[k] = -1; r_at[k] = -1; x_lo[k] = -1; x_hi[k] = -1;
            end else if (m_idle[k]) begin
                if (start[k]) begin
                    m_idle[k] = 1'b0;
                    f_at[k]   = n + 1;
                end
            end else if (!m_halt[k]) begin
                if (n == f_at[k] + 1) begin
                    w = mem[k][m_pc[k]];
                    if (w[15:13] == 3'b111) begin
                        m_halt[k] = 1'b1;
                    end else begin
                        m_din[k] = w;
                        m_pc[k]  = m_pc[k] + 8'd1;
                        r_at[k]  = n + 1;
                        x_lo[k]  = n + 2;
                        x_hi[k]  = n + 1 + TIMEOUT;
                    end
                end else if (n >= x_lo[k] && n <= x_hi[k]) begin
                    if (Done[k]) begin
                        if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
                        x_lo[k] = -1; x_hi[k] = -1;
`ifdef FETCH_STEP_EN
                        m_sw[k] = 1'b1;
`else
                        f_at[k] = n + 1;
`endif
                    end else if (n == x_hi[k]) begin
                        m_halt[k] = 1'b1;
                        m_to[k]   = 1'b1;
                    end
                end else if (m_sw[k] && step[k]) begin
                    m_sw[k] = 1'b0;
                    f_at[k] = n + 1;
                end
            end
        end
    end

    // processor model, logging and the per-cycle compare
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (Run[k]) last_run_cyc[k] = cyc;
            Done[k] = done_force[k] || (done_delay[k] >= 0 && cyc == last_run_cyc[k] + done_delay[k])
                      || (done_rand[k] && $urandom_range(0, 5) == 0);
            step[k] = step_hold[k] || (step_rand[k] && $urandom_range(0, 3) == 0);
            if (chk_en) begin
                chk("mem_rd", k, mem_rd[k], cyc == f_at[k]);
                chk("mem_addr", k, mem_addr[k], m_pc[k]);
                chk("Run", k, Run[k], cyc == r_at[k]);
                chk("Din", k, Din[k], m_din[k]);
                chk("pc", k, pc[k], m_pc[k]);
                chk("busy", k, busy[k], !m_idle[k] && !m_halt[k]);
                chk("halted", k, halted[k], m_halt[k]);
                chk("timeout_err", k, timeout_err[k], m_to[k]);
                chk("instr_cnt", k, instr_cnt[k], m_cnt[k]);
            end
        end
        if (mem_rd[0]) begin rd_q0.push_back(mem_addr[0]); rd_c0.push_back(cyc); end
        if (mem_rd[1]) rd_q1.push_back(mem_addr[1]);
        if (Run[0]) begin run_q0.push_back(Din[0]); run_c0.push_back(cyc); end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        Rest[k] = 1'b1;
        tick();
        Rest[k] = 1'b0;
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic clear_logs();
        run_q0.delete(); run_c0.delete(); rd_q0.delete(); rd_c0.delete();
    endtask

    task automatic wait_halt(input int k, input int budget, input string name);
        int i;
        i = 0;
        while (!halted[k] && i < budget) begin
            tick();
            i++;
        end
        chk({name, "_halt_wait"}, k, halted[k], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t, expected below 1000000", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int t0;
        int i;
        int n;
        logic [15:0] w;
        for (int k = 0; k < 2; k++) begin
            done_delay[k] = -1; done_rand[k] = 0; done_force[k] = 0;
            step_hold[k] = 1; step_rand[k] = 0; last_run_cyc[k] = -1000;
        end
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = 16'hE000;
            mem[1][a] = 16'hE000;
        end
        Rest  = 2'b11;
        start = 2'b00;
        tick();
        chk_en = 1'b1;
        tick();
        Rest = 2'b00;

        // reset values
        chk("rst_pc", 0, pc[0], 8'h00);
        chk("rst_pc", 1, pc[1], 8'hFF);
        chk("rst_din", 0, Din[0], 16'h0000);
        chk("rst_cnt", 0, instr_cnt[0], 16'h0000);
        chk("rst_run", 0, Run[0], 0);
        chk("rst_mem_rd", 0, mem_rd[0], 0);
        chk("rst_halted", 0, halted[0], 0);

        // Done in IDLE is ignored
        done_force[0] = 1;
        tick();
        done_force[0] = 0;
        repeat (3) tick();
        chk("idle_done_cnt", 0, instr_cnt[0], 16'h0000);
        chk("idle_done_busy", 0, busy[0], 0);

        // short program run to HALT
        mem[0][0] = 16'h3005; mem[0][1] = 16'h0201; mem[0][2] = 16'hE000;
        done_delay[0] = 2;
        clear_logs();
        t0 = cyc;
        pulse_start(0);
        wait_halt(0, 200, "prog");
        chk("prog_runs", 0, run_q0.size(), 2);
        if (run_q0.size() == 2) begin
            chk("prog_din0", 0, run_q0[0], 16'h3005);
            chk("prog_din1", 0, run_q0[1], 16'h0201);
            chk("prog_run_lat", 0, run_c0[0] - t0, 3);
            chk("prog_rd_lat", 0, rd_c0[0] - t0, 1);
        end
        chk("prog_pc", 0, pc[0], 8'd2);
        chk("prog_cnt", 0, instr_cnt[0], 16'd2);
        chk("prog_to", 0, timeout_err[0], 0);
        n = rd_q0.size();
        pulse_start(0);
        repeat (10) tick();
        chk("halt_start_rd", 0, rd_q0.size(), n);
        chk("halt_no_run", 0, run_q0.size(), 2);

        // watchdog expiry
        do_reset(0);
        mem[0][0] = 16'h1000;
        done_delay[0] = -1;
        clear_logs();
        pulse_start(0);
        wait_halt(0, 100, "wdog");
        chk("wdog_to", 0, timeout_err[0], 1);
        chk("wdog_pc", 0, pc[0], 8'd1);
        chk("wdog_cnt", 0, instr_cnt[0], 16'd0);
        if (run_c0.size() == 1) chk("wdog_len", 0, cyc - run_c0[0], 16);

        // Done on the 15th EXEC cycle
        do_reset(0);
        mem[0][0] = 16'h1000; mem[0][1] = 16'hE000;
        done_delay[0] = 15;
        clear_logs();
        pulse_start(0);
        wait_halt(0, 100, "d15");
        chk("d15_to", 0, timeout_err[0], 0);
        chk("d15_cnt", 0, instr_cnt[0], 16'd1);
        chk("d15_pc", 0, pc[0], 8'd1);
        chk("d15_rds", 0, rd_q0.size(), 2);
        if (rd_c0.size() == 2 && run_c0.size() == 1)
`ifdef FETCH_STEP_EN
            chk("d15_next_rd", 0, rd_c0[1] - run_c0[0], 17);
`else
            chk("d15_next_rd", 0, rd_c0[1] - run_c0[0], 16);
`endif

        // reset in the middle of EXEC
        do_reset(0);
        for (int a = 0; a < 4; a++) mem[0][a] = 16'h1000;
        done_delay[0] = 2;
        clear_logs();
        pulse_start(0);
        i = 0;
        while (run_q0.size() < 3 && i < 200) begin tick(); i++; end
        chk("mid_runs", 0, run_q0.size(), 3);
        tick();
        chk("mid_cnt_before", 0, instr_cnt[0], 16'd2);
        Rest[0] = 1'b1;
        tick();
        Rest[0] = 1'b0;
        chk("mid_run", 0, Run[0], 0);
        chk("mid_pc", 0, pc[0], 8'h00);
        chk("mid_cnt", 0, instr_cnt[0], 16'd0);
        chk("mid_din", 0, Din[0], 16'h0000);
        chk("mid_busy", 0, busy[0], 0);
        clear_logs();
        pulse_start(0);
        repeat (3) tick();
        chk("mid_refetch_n", 0, rd_q0.size(), 1);
        if (rd_q0.size() == 1) chk("mid_refetch_addr", 0, rd_q0[0], 8'h00);

        // PC wrap on the RESET_PC=FF instance
        mem[1][8'hFF] = 16'h1000; mem[1][0] = 16'hE000;
        done_delay[1] = 2;
        rd_q1.delete();
        pulse_start(1);
        wait_halt(1, 100, "wrap");
        chk("wrap_pc", 1, pc[1], 8'h00);
        chk("wrap_cnt", 1, instr_cnt[1], 16'd1);
        chk("wrap_rds", 1, rd_q1.size(), 2);
        if (rd_q1.size() == 2) begin
            chk("wrap_addr0", 1, rd_q1[0], 8'hFF);
            chk("wrap_addr1", 1, rd_q1[1], 8'h00);
        end

`ifdef FETCH_STEP_EN
        // step gates the fetch after Done
        do_reset(0);
        mem[0][0] = 16'h1000; mem[0][1] = 16'hE000;
        done_delay[0] = 2;
        step_hold[0] = 0;
        clear_logs();
        pulse_start(0);
        i = 0;
        while (run_q0.size() < 1 && i < 50) begin tick(); i++; end
        repeat (12) tick();
        chk("step_hold_rd", 0, rd_q0.size(), 1);
        chk("step_hold_busy", 0, busy[0], 1);
        chk("step_hold_cnt", 0, instr_cnt[0], 16'd1);
        step_hold[0] = 1;
        t0 = cyc + 1;
        tick();
        step_hold[0] = 0;
        repeat (3) tick();
        chk("step_rds", 0, rd_q0.size(), 2);
        if (rd_c0.size() == 2) chk("step_rd_lat", 0, rd_c0[1] - t0, 1);
        step_hold[0] = 1;
`endif

        // randomized runs
        for (int round = 0; round < 25; round++) begin
            do_reset(0);
            for (int a = 0; a < 256; a++) begin
                w = 16'($urandom);
                if (w[15:13] == 3'b111 && $urandom_range(0, 3) != 0) w[15] = 1'b0;
                mem[0][a] = w;
            end
            done_delay[0] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 18));
            done_rand[0]  = 1'($urandom_range(0, 1));
            step_hold[0]  = 1'($urandom_range(0, 1));
            step_rand[0]  = 1'b1;
            pulse_start(0);
            for (int c = 0; c < 300; c++) begin
                start[0] = ($urandom_range(0, 15) == 0);
                Rest[0]  = ($urandom_range(0, 199) == 0);
                tick();
            end
            start[0] = 1'b0;
            Rest[0]  = 1'b0;
        end
        done_rand[0] = 0;
        step_rand[0] = 0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
